// File: rtl/flash_arb_pkg.sv
// Shared types and address helpers for the flash read arbiter.
// Optional feature macro used by this block: FLASH_ARB_RR_EN (round-robin tie-break).
package flash_arb_pkg;

    localparam int FLASH_AW = 23;
    localparam int LOCAL_AW = 22;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    typedef enum logic {
        PORT_PRG = 1'b0,
        PORT_CHR = 1'b1
    } port_t;

    // Window mapping wraps modulo 2^23; an overflowing window is silently folded.
    function automatic logic [FLASH_AW-1:0] map_addr(input logic [FLASH_AW-1:0] base,
                                                     input logic [LOCAL_AW-1:0] addr);
        return base + {1'b0, addr};
    endfunction

endpackage

// File: rtl/flash_arb_grant.sv
// Combinational winner select between PRG and CHR; a port is not eligible while its own ack is high.
// FLASH_ARB_RR_EN selects round-robin tie-break, otherwise CHR has fixed priority.
module flash_arb_grant
    import flash_arb_pkg::*;
(
    input  logic  prg_req,
    input  logic  chr_req,
    input  logic  prg_ack,
    input  logic  chr_ack,
`ifdef FLASH_ARB_RR_EN
    input  port_t last_grant,
`endif
    output logic  grant_vld,
    output port_t grant_port
);

    logic prg_elig;
    logic chr_elig;
    logic pick_chr;

    assign prg_elig  = prg_req & ~prg_ack;
    assign chr_elig  = chr_req & ~chr_ack;
    assign grant_vld = prg_elig | chr_elig;

`ifdef FLASH_ARB_RR_EN
    // On a tie the port that did not win last time goes next.
    assign pick_chr = chr_elig & (~prg_elig | (last_grant == PORT_PRG));
`else
    // Rendering deadlines are harder than CPU fetch, so CHR always wins a tie.
    assign pick_chr = chr_elig;
`endif

    assign grant_port = pick_chr ? PORT_CHR : PORT_PRG;

endmodule

// File: rtl/flash_rd_arbiter.sv
// Shares one async-read parallel flash between PRG and CHR fetch, one access in flight at a time.
// Ack arrives 1+ACCESS_CYC cycles after a grant; tie-break mode set by FLASH_ARB_RR_EN.
module flash_rd_arbiter
    import flash_arb_pkg::*;
#(
    parameter int          ACCESS_CYC = 4,
    parameter logic [22:0] PRG_BASE   = 23'h000000,
    parameter logic [22:0] CHR_BASE   = 23'h400000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_prg_req,
    input  logic [21:0] i_prg_addr,
    output logic        o_prg_ack,
    output logic [7:0]  o_prg_data,
    input  logic        i_chr_req,
    input  logic [21:0] i_chr_addr,
    output logic        o_chr_ack,
    output logic [7:0]  o_chr_data,
    output logic [22:0] o_flash_addr,
    output logic        o_flash_ce_n,
    input  logic [7:0]  i_flash_q
);

    localparam int               CNT_W    = (ACCESS_CYC > 1) ? $clog2(ACCESS_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYC - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    port_t            owner;
    logic             grant_vld;
    port_t            grant_port;

    // owner doubles as the last-grant record for round-robin; it resets to CHR.
    flash_arb_grant u_grant (
        .prg_req    (i_prg_req),
        .chr_req    (i_chr_req),
        .prg_ack    (o_prg_ack),
        .chr_ack    (o_chr_ack),
`ifdef FLASH_ARB_RR_EN
        .last_grant (owner),
`endif
        .grant_vld  (grant_vld),
        .grant_port (grant_port)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            owner        <= PORT_CHR;
            o_prg_ack    <= 1'b0;
            o_chr_ack    <= 1'b0;
            o_prg_data   <= 8'h00;
            o_chr_data   <= 8'h00;
            o_flash_addr <= '0;
            o_flash_ce_n <= 1'b1;
        end else begin
            o_prg_ack <= 1'b0;
            o_chr_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        owner        <= grant_port;
                        o_flash_addr <= (grant_port == PORT_CHR) ? map_addr(CHR_BASE, i_chr_addr)
                                                                 : map_addr(PRG_BASE, i_prg_addr);
                        o_flash_ce_n <= 1'b0;
                        cnt          <= CNT_LOAD;
                        state        <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        // Address stays put after the access; only CE marks the bus idle.
                        if (owner == PORT_CHR) begin
                            o_chr_data <= i_flash_q;
                            o_chr_ack  <= 1'b1;
                        end else begin
                            o_prg_data <= i_flash_q;
                            o_prg_ack  <= 1'b1;
                        end
                        o_flash_ce_n <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flash_rd_arbiter.sv
// Bench for flash_rd_arbiter: directed scenarios plus a randomized run against a cycle-count reference model.
`timescale 1ns/1ps
module tb_flash_rd_arbiter;

    localparam int          AC       = 4;
    localparam logic [22:0] PRG_BASE = 23'h000000;
    localparam logic [22:0] CHR_BASE = 23'h400000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        prg_req = 1'b0;
    logic        chr_req = 1'b0;
    logic [21:0] prg_addr = '0;
    logic [21:0] chr_addr = '0;
    logic        prg_ack, chr_ack;
    logic [7:0]  prg_data, chr_data, flash_q;
    logic [22:0] flash_addr;
    logic        flash_ce_n;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    flash_rd_arbiter #(.ACCESS_CYC(AC), .PRG_BASE(PRG_BASE), .CHR_BASE(CHR_BASE)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_prg_req    (prg_req),
        .i_prg_addr   (prg_addr),
        .o_prg_ack    (prg_ack),
        .o_prg_data   (prg_data),
        .i_chr_req    (chr_req),
        .i_chr_addr   (chr_addr),
        .o_chr_ack    (chr_ack),
        .o_chr_data   (chr_data),
        .o_flash_addr (flash_addr),
        .o_flash_ce_n (flash_ce_n),
        .i_flash_q    (flash_q)
    );

    // Flash contents: two fixed bytes plus an address hash everywhere else.
    function automatic logic [7:0] memf(input logic [22:0] a);
        if (a == 23'h000010) return 8'hA5;
        if (a == 23'h400123) return 8'h3C;
        return a[7:0] ^ a[15:8] ^ {a[22:16], 1'b1};
    endfunction

    assign flash_q = flash_ce_n ? 8'hEE : memf(flash_addr);

    task automatic do_reset;
        rst_n   = 1'b0;
        prg_req = 1'b0;
        chr_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        logic [22:0] win_addr;
`ifdef FLASH_ARB_RR_EN
        win_addr = PRG_BASE + 23'h10;
`else
        win_addr = CHR_BASE + 23'h123;
`endif
        rst_n = 1'b0; prg_req = 1'b1; chr_req = 1'b1;
        prg_addr = 22'h10; chr_addr = 22'h123;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (c <= 2) begin
                vectors++; if (prg_ack !== 1'b0) begin errors++; $display("FAIL reset_prg_ack c%0d: got %h want 0", c, prg_ack); end
                vectors++; if (chr_ack !== 1'b0) begin errors++; $display("FAIL reset_chr_ack c%0d: got %h want 0", c, chr_ack); end
                vectors++; if (prg_data !== 8'h00) begin errors++; $display("FAIL reset_prg_data c%0d: got %h want 00", c, prg_data); end
                vectors++; if (chr_data !== 8'h00) begin errors++; $display("FAIL reset_chr_data c%0d: got %h want 00", c, chr_data); end
                vectors++; if (flash_addr !== 23'h0) begin errors++; $display("FAIL reset_addr c%0d: got %h want 0", c, flash_addr); end
                vectors++; if (flash_ce_n !== 1'b1) begin errors++; $display("FAIL reset_ce_n c%0d: got %h want 1", c, flash_ce_n); end
                if (c == 2) rst_n = 1'b1;
            end else begin
                vectors++; if (flash_ce_n !== 1'b0) begin errors++; $display("FAIL reset_first_grant_ce: got %h want 0", flash_ce_n); end
                vectors++; if (flash_addr !== win_addr) begin errors++; $display("FAIL reset_first_grant_addr: got %h want %h", flash_addr, win_addr); end
            end
        end
        do_reset;
    endtask

    task automatic test_single_read;
        logic [22:0] ea;
        logic [7:0]  ed, d;
        logic        a, oa;
        for (int i = 0; i < 2; i++) begin
            do_reset;
            if (i == 0) begin prg_req = 1'b1; prg_addr = 22'h10; ea = 23'h000010; ed = 8'hA5; end
            else        begin chr_req = 1'b1; chr_addr = 22'h123; ea = 23'h400123; ed = 8'h3C; end
            for (int c = 1; c <= 8; c++) begin
                @(negedge clk);
                a  = (i == 0) ? prg_ack : chr_ack;
                oa = (i == 0) ? chr_ack : prg_ack;
                d  = (i == 0) ? prg_data : chr_data;
                vectors++; if (flash_ce_n !== (c > AC)) begin errors++; $display("FAIL read%0d_ce_n c%0d: got %h want %h", i, c, flash_ce_n, (c > AC)); end
                vectors++; if (a !== (c == AC + 1)) begin errors++; $display("FAIL read%0d_ack c%0d: got %h want %h", i, c, a, (c == AC + 1)); end
                vectors++; if (oa !== 1'b0) begin errors++; $display("FAIL read%0d_other_ack c%0d: got %h want 0", i, c, oa); end
                vectors++; if (flash_addr !== ea) begin errors++; $display("FAIL read%0d_addr c%0d: got %h want %h", i, c, flash_addr, ea); end
                vectors++; if (d !== ((c >= AC + 1) ? ed : 8'h00)) begin errors++; $display("FAIL read%0d_data c%0d: got %h want %h", i, c, d, ((c >= AC + 1) ? ed : 8'h00)); end
                if (c == AC + 1) begin prg_req = 1'b0; chr_req = 1'b0; end
            end
        end
    endtask

    task automatic test_tie;
        int          pc, cc;
        logic [21:0] pa, ca;
        do_reset;
        for (int r = 0; r < 2; r++) begin
            // Second round: a lone PRG read first, so the tie that follows sees PRG as last winner.
            if (r == 1) begin
                prg_req = 1'b1; prg_addr = 22'h10;
                repeat (AC + 1) @(negedge clk);
                prg_req = 1'b0;
                @(negedge clk);
            end
            pa = 22'($urandom); ca = 22'($urandom);
            prg_req = 1'b1; chr_req = 1'b1; prg_addr = pa; chr_addr = ca;
`ifdef FLASH_ARB_RR_EN
            pc = (r == 0) ? AC + 1 : 2 * AC + 2;
`else
            pc = 2 * AC + 2;
`endif
            cc = (pc == AC + 1) ? 2 * AC + 2 : AC + 1;
            for (int c = 1; c <= 2 * AC + 4; c++) begin
                @(negedge clk);
                vectors++; if (prg_ack !== (c == pc)) begin errors++; $display("FAIL tie%0d_prg_ack c%0d: got %h want %h", r, c, prg_ack, (c == pc)); end
                vectors++; if (chr_ack !== (c == cc)) begin errors++; $display("FAIL tie%0d_chr_ack c%0d: got %h want %h", r, c, chr_ack, (c == cc)); end
                vectors++; if (flash_ce_n !== (c == AC + 1 || c >= 2 * AC + 2)) begin errors++; $display("FAIL tie%0d_ce_n c%0d: got %h", r, c, flash_ce_n); end
                if (c == pc) begin
                    vectors++; if (prg_data !== memf(PRG_BASE + {1'b0, pa})) begin errors++; $display("FAIL tie%0d_prg_data: got %h want %h", r, prg_data, memf(PRG_BASE + {1'b0, pa})); end
                    prg_req = 1'b0;
                end
                if (c == cc) begin
                    vectors++; if (chr_data !== memf(CHR_BASE + {1'b0, ca})) begin errors++; $display("FAIL tie%0d_chr_data: got %h want %h", r, chr_data, memf(CHR_BASE + {1'b0, ca})); end
                    chr_req = 1'b0;
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        do_reset;
        prg_req = 1'b1; prg_addr = 22'h10;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c >= 2) begin
                vectors++; if (prg_ack !== 1'b0) begin errors++; $display("FAIL rstmid_ack c%0d: got %h want 0", c, prg_ack); end
                vectors++; if (flash_ce_n !== 1'b1) begin errors++; $display("FAIL rstmid_ce_n c%0d: got %h want 1", c, flash_ce_n); end
                vectors++; if (flash_addr !== 23'h0) begin errors++; $display("FAIL rstmid_addr c%0d: got %h want 0", c, flash_addr); end
                vectors++; if (prg_data !== 8'h00) begin errors++; $display("FAIL rstmid_data c%0d: got %h want 00", c, prg_data); end
            end
            if (c == 1) begin rst_n = 1'b0; prg_req = 1'b0; end
            if (c == 2) rst_n = 1'b1;
        end
        prg_req = 1'b1; prg_addr = 22'h10;
        for (int c = 1; c <= AC + 2; c++) begin
            @(negedge clk);
            vectors++; if (prg_ack !== (c == AC + 1)) begin errors++; $display("FAIL rstmid_new_ack c%0d: got %h want %h", c, prg_ack, (c == AC + 1)); end
            if (c == AC + 1) begin
                vectors++; if (prg_data !== 8'hA5) begin errors++; $display("FAIL rstmid_new_data: got %h want a5", prg_data); end
                prg_req = 1'b0;
            end
        end
    endtask

    task automatic test_held_req;
        logic [21:0] cur;
        do_reset;
        cur = 22'($urandom);
        prg_req = 1'b1; prg_addr = cur;
        for (int c = 1; c <= 5 * (AC + 2); c++) begin
            @(negedge clk);
            vectors++; if (prg_ack !== (c % (AC + 2) == AC + 1)) begin errors++; $display("FAIL held_ack c%0d: got %h want %h", c, prg_ack, (c % (AC + 2) == AC + 1)); end
            vectors++; if (flash_ce_n !== (c % (AC + 2) == AC + 1 || c % (AC + 2) == 0)) begin errors++; $display("FAIL held_ce_n c%0d: got %h", c, flash_ce_n); end
            if (c % (AC + 2) == 1) begin
                vectors++; if (flash_addr !== PRG_BASE + {1'b0, cur}) begin errors++; $display("FAIL held_addr c%0d: got %h want %h", c, flash_addr, PRG_BASE + {1'b0, cur}); end
            end
            if (c % (AC + 2) == AC + 1) begin
                vectors++; if (prg_data !== memf(PRG_BASE + {1'b0, cur})) begin errors++; $display("FAIL held_data c%0d: got %h want %h", c, prg_data, memf(PRG_BASE + {1'b0, cur})); end
                cur = 22'($urandom);
                prg_addr = cur;
            end
        end
        prg_req = 1'b0;
    endtask

    // Reference model works in absolute cycle numbers: when the bus frees up,
    // who is eligible, and the cycle at which each ack must appear.
    task automatic test_random;
        int          free_at, pa_at, ca_at, ce_first, ce_last;
        logic [7:0]  ep_d, ec_d, pp_d, pc_d;
        logic [22:0] e_addr;
        logic        last_chr, pe, cel, gchr;
        do_reset;
        free_at = 0; pa_at = -1; ca_at = -1; ce_first = -1; ce_last = -2;
        ep_d = 8'h00; ec_d = 8'h00; pp_d = 8'h00; pc_d = 8'h00;
        e_addr = '0; last_chr = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            if (k == pa_at) ep_d = pp_d;
            if (k == ca_at) ec_d = pc_d;
            vectors++; if (prg_ack !== (k == pa_at)) begin errors++; $display("FAIL rnd_prg_ack k%0d: got %h want %h", k, prg_ack, (k == pa_at)); end
            vectors++; if (chr_ack !== (k == ca_at)) begin errors++; $display("FAIL rnd_chr_ack k%0d: got %h want %h", k, chr_ack, (k == ca_at)); end
            vectors++; if (prg_data !== ep_d) begin errors++; $display("FAIL rnd_prg_data k%0d: got %h want %h", k, prg_data, ep_d); end
            vectors++; if (chr_data !== ec_d) begin errors++; $display("FAIL rnd_chr_data k%0d: got %h want %h", k, chr_data, ec_d); end
            vectors++; if (flash_ce_n !== !(k >= ce_first && k <= ce_last)) begin errors++; $display("FAIL rnd_ce_n k%0d: got %h", k, flash_ce_n); end
            vectors++; if (flash_addr !== e_addr) begin errors++; $display("FAIL rnd_addr k%0d: got %h want %h", k, flash_addr, e_addr); end

            // Requesters: hold until ack, sometimes drop early, sometimes keep going with a new address.
            if (!prg_req) begin
                if ($urandom % 3 == 0) begin prg_req = 1'b1; prg_addr = 22'($urandom); end
            end else if (prg_ack) begin
                if ($urandom % 2 == 0) prg_addr = 22'($urandom); else prg_req = 1'b0;
            end else if ($urandom % 40 == 0) prg_req = 1'b0;
            if (!chr_req) begin
                if ($urandom % 3 == 0) begin chr_req = 1'b1; chr_addr = 22'($urandom); end
            end else if (chr_ack) begin
                if ($urandom % 2 == 0) chr_addr = 22'($urandom); else chr_req = 1'b0;
            end else if ($urandom % 40 == 0) chr_req = 1'b0;
            rst_n = ($urandom % 300 != 0);

            if (!rst_n) begin
                free_at = k + 1; pa_at = -1; ca_at = -1; ce_first = -1; ce_last = -2;
                ep_d = 8'h00; ec_d = 8'h00; e_addr = '0; last_chr = 1'b1;
            end else if (k >= free_at) begin
                pe  = prg_req && (pa_at != k);
                cel = chr_req && (ca_at != k);
                if (pe || cel) begin
                    if (pe && cel) begin
`ifdef FLASH_ARB_RR_EN
                        gchr = !last_chr;
`else
                        gchr = 1'b1;
`endif
                    end else begin
                        gchr = cel;
                    end
                    last_chr = gchr;
                    free_at  = k + 1 + AC;
                    ce_first = k + 1;
                    ce_last  = k + AC;
                    if (gchr) begin
                        e_addr = CHR_BASE + {1'b0, chr_addr}; pc_d = memf(e_addr); ca_at = k + 1 + AC;
                    end else begin
                        e_addr = PRG_BASE + {1'b0, prg_addr}; pp_d = memf(e_addr); pa_at = k + 1 + AC;
                    end
                end
            end
            @(negedge clk);
        end
        rst_n = 1'b1; prg_req = 1'b0; chr_req = 1'b0;
    endtask

    initial begin
        test_reset;
        test_single_read;
        test_tie;
        test_reset_mid;
        test_held_req;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
